// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY receive link bring-up/supervision FSM with error accumulator.
// Optional PRBS31 test-mode state is compiled in when ETH_PHY_LINK_PRBS_EN is defined.
module eth_phy_10g_link_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned HOLDOFF_CYCLES = 64
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        phy_rx_block_lock,
  input  logic        phy_rx_high_ber,
  input  logic        phy_rx_status,
  input  logic [6:0]  phy_rx_error_count,
  input  logic        phy_serdes_rx_reset_req,
  input  logic        prbs_req,
  input  logic        err_clear,
  output logic        serdes_rst_out,
  output logic        link_up,
  output logic [2:0]  link_state,
  output logic [7:0]  retry_count,
  output logic [15:0] err_accum,
  output logic        cfg_tx_prbs31_enable,
  output logic        cfg_rx_prbs31_enable,
  output logic        prbs_active
);

  typedef enum logic [2:0] {
    StSerdesRst  = 3'd0,
    StWaitLock   = 3'd1,
    StWaitStatus = 3'd2,
    StLinkUp     = 3'd3,
    StHoldoff    = 3'd4,
    StPrbs       = 3'd5
  } state_e;

  localparam logic [15:0] RstLast  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LockLast = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] HoldLast = 16'(HOLDOFF_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] err_q, err_d;
  logic        keep_timer;
  logic        retry_inc;
  logic        accum_en;
  logic [16:0] err_sum;

  always_comb begin
    state_d    = state_q;
    keep_timer = 1'b0;
    retry_inc  = 1'b0;
    case (state_q)
      StSerdesRst: begin
        if (timer_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (phy_rx_block_lock) begin
          // Timeout budget is shared across both wait states.
          state_d    = StWaitStatus;
          keep_timer = 1'b1;
        end else if (timer_q >= LockLast) begin
          state_d   = StSerdesRst;
          retry_inc = 1'b1;
        end
      end
      StWaitStatus: begin
        if (!phy_rx_block_lock) begin
          state_d = StWaitLock;
        end else if (phy_rx_status) begin
          state_d = StLinkUp;
        end else if (timer_q >= LockLast) begin
          state_d   = StSerdesRst;
          retry_inc = 1'b1;
        end
      end
      StLinkUp: begin
        if (!phy_rx_block_lock || phy_rx_high_ber || phy_serdes_rx_reset_req) begin
          state_d = StHoldoff;
`ifdef ETH_PHY_LINK_PRBS_EN
        end else if (prbs_req) begin
          state_d = StPrbs;
`endif
        end
      end
      StHoldoff: begin
        if (timer_q == HoldLast) state_d = StSerdesRst;
      end
`ifdef ETH_PHY_LINK_PRBS_EN
      StPrbs: begin
        if (!prbs_req) state_d = StSerdesRst;
      end
`endif
      default: state_d = StSerdesRst;
    endcase

    timer_d = (state_d != state_q && !keep_timer) ? 16'd0 : timer_q + 16'd1;

    retry_d = retry_q;
    if (err_clear) begin
      retry_d = 8'd0;
    end else if (retry_inc && retry_q != 8'hFF) begin
      retry_d = retry_q + 8'd1;
    end

`ifdef ETH_PHY_LINK_PRBS_EN
    accum_en = (state_q == StLinkUp) || (state_q == StPrbs);
`else
    accum_en = (state_q == StLinkUp);
`endif
    err_sum = {1'b0, err_q} + {10'd0, phy_rx_error_count};
    err_d   = err_q;
    if (err_clear) begin
      err_d = 16'd0;
    end else if (accum_en) begin
      err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q <= StSerdesRst;
      timer_q <= 16'd0;
      retry_q <= 8'd0;
      err_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    serdes_rst_out = (state_q == StSerdesRst);
    link_up        = (state_q == StLinkUp);
    link_state     = state_q;
    retry_count    = retry_q;
    err_accum      = err_q;
`ifdef ETH_PHY_LINK_PRBS_EN
    prbs_active    = (state_q == StPrbs);
`else
    prbs_active    = 1'b0;
`endif
    cfg_tx_prbs31_enable = prbs_active;
    cfg_rx_prbs31_enable = prbs_active;
  end

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Directed bench for eth_phy_10g_link_ctrl (RST_CYCLES=16, LOCK_TIMEOUT=32, HOLDOFF_CYCLES=64).
// Honours ETH_PHY_LINK_PRBS_EN for the PRBS scenario.
module tb_eth_phy_10g_link_ctrl;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        lock, ber, status, reset_req, prbs_req, err_clear;
  logic [6:0]  err_cnt;
  logic        serdes_rst_out, link_up;
  logic [2:0]  link_state;
  logic [7:0]  retry_count;
  logic [15:0] err_accum;
  logic        tx_prbs, rx_prbs, prbs_active;

  int errors = 0;
  int checks = 0;

  eth_phy_10g_link_ctrl #(
    .RST_CYCLES     (16),
    .LOCK_TIMEOUT   (32),
    .HOLDOFF_CYCLES (64)
  ) dut (
    .rx_clk                  (rx_clk),
    .rx_rst                  (rx_rst),
    .phy_rx_block_lock       (lock),
    .phy_rx_high_ber         (ber),
    .phy_rx_status           (status),
    .phy_rx_error_count      (err_cnt),
    .phy_serdes_rx_reset_req (reset_req),
    .prbs_req                (prbs_req),
    .err_clear               (err_clear),
    .serdes_rst_out          (serdes_rst_out),
    .link_up                 (link_up),
    .link_state              (link_state),
    .retry_count             (retry_count),
    .err_accum               (err_accum),
    .cfg_tx_prbs31_enable    (tx_prbs),
    .cfg_rx_prbs31_enable    (rx_prbs),
    .prbs_active             (prbs_active)
  );

  always #5 rx_clk = ~rx_clk;

  // Advance n rising edges, then settle 1 time unit before sampling/driving.
  task automatic tick(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic test_reset();
    rx_rst = 1'b1; lock = 1'b0; ber = 1'b0; status = 1'b0; reset_req = 1'b0;
    prbs_req = 1'b0; err_clear = 1'b0; err_cnt = 7'd0;
    tick(2);
    checks++;
    if ({serdes_rst_out, link_up, link_state, retry_count, err_accum, tx_prbs, rx_prbs,
         prbs_active} !== {1'b1, 1'b0, 3'd0, 8'd0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got rst=%b up=%b st=%0d retry=%0d err=%0d prbs=%b%b%b",
               serdes_rst_out, link_up, link_state, retry_count, err_accum, tx_prbs, rx_prbs,
               prbs_active);
    end
  endtask

  task automatic test_bringup();
    int bad = 0;
    lock = 1'b1; status = 1'b1;
    rx_rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (serdes_rst_out !== 1'b1 || link_state !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bringup_rst_hold: %0d of edges 1..15 left SERDES_RST, want 0", bad);
    end
    tick(1);
    checks++;
    if (serdes_rst_out !== 1'b0 || link_state !== 3'd1) begin
      errors++;
      $display("FAIL bringup_edge16: rst=%b st=%0d, want rst=0 st=1", serdes_rst_out, link_state);
    end
    tick(1);
    checks++;
    if (link_state !== 3'd2 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL bringup_edge17: st=%0d up=%b, want st=2 up=0", link_state, link_up);
    end
    tick(1);
    checks++;
    if (link_state !== 3'd3 || link_up !== 1'b1) begin
      errors++;
      $display("FAIL bringup_edge18: st=%0d up=%b, want st=3 up=1", link_state, link_up);
    end
  endtask

  task automatic test_holdoff();
    ber = 1'b1;
    tick(1);
    ber = 1'b0;
    checks++;
    if (link_up !== 1'b0 || link_state !== 3'd4) begin
      errors++;
      $display("FAIL holdoff_enter: up=%b st=%0d, want up=0 st=4", link_up, link_state);
    end
    tick(63);
    checks++;
    if (link_state !== 3'd4) begin
      errors++;
      $display("FAIL holdoff_len63: st=%0d, want 4", link_state);
    end
    tick(1);
    checks++;
    if (link_state !== 3'd0 || serdes_rst_out !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_exit: st=%0d rst=%b, want st=0 rst=1", link_state, serdes_rst_out);
    end
    tick(18);
    checks++;
    if (link_up !== 1'b1 || link_state !== 3'd3) begin
      errors++;
      $display("FAIL holdoff_relink: up=%b st=%0d, want up=1 st=3", link_up, link_state);
    end
  endtask

  task automatic test_err_accum();
    err_cnt = 7'd100;
    tick(3);
    checks++;
    if (err_accum !== 16'd300) begin
      errors++;
      $display("FAIL accum_300: got %0d, want 300", err_accum);
    end
    tick(697);
    checks++;
    if (err_accum !== 16'hFFFF) begin
      errors++;
      $display("FAIL accum_saturate: got 0x%h, want 0xffff", err_accum);
    end
    err_cnt = 7'd5; err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0; err_cnt = 7'd0;
    checks++;
    if (err_accum !== 16'd0) begin
      errors++;
      $display("FAIL accum_clear: got %0d, want 0", err_accum);
    end
  endtask

  task automatic test_prbs();
    prbs_req = 1'b1;
    tick(1);
`ifdef ETH_PHY_LINK_PRBS_EN
    checks++;
    if ({link_state, tx_prbs, rx_prbs, prbs_active, link_up} !== {3'd5, 4'b1110}) begin
      errors++;
      $display("FAIL prbs_enter: st=%0d prbs=%b%b%b up=%b, want st=5 prbs=111 up=0",
               link_state, tx_prbs, rx_prbs, prbs_active, link_up);
    end
    lock = 1'b0;
    tick(2);
    checks++;
    if (link_state !== 3'd5) begin
      errors++;
      $display("FAIL prbs_ignore_lock: st=%0d, want 5", link_state);
    end
    prbs_req = 1'b0; lock = 1'b1;
    tick(1);
    checks++;
    if (link_state !== 3'd0 || serdes_rst_out !== 1'b1 || prbs_active !== 1'b0) begin
      errors++;
      $display("FAIL prbs_exit: st=%0d rst=%b act=%b, want st=0 rst=1 act=0",
               link_state, serdes_rst_out, prbs_active);
    end
`else
    tick(2);
    checks++;
    if ({link_state, tx_prbs, rx_prbs, prbs_active} !== {3'd3, 3'b000}) begin
      errors++;
      $display("FAIL prbs_disabled: st=%0d prbs=%b%b%b, want st=3 prbs=000",
               link_state, tx_prbs, rx_prbs, prbs_active);
    end
    prbs_req = 1'b0;
`endif
  endtask

  task automatic test_reset_midop();
    rx_rst = 1'b1; tick(1); rx_rst = 1'b0;
    lock = 1'b0; status = 1'b0;
    tick(96);
    checks++;
    if (retry_count !== 8'd2 || link_state !== 3'd0) begin
      errors++;
      $display("FAIL midop_retry2: retry=%0d st=%0d, want retry=2 st=0", retry_count, link_state);
    end
    lock = 1'b1; status = 1'b1;
    tick(18);
    err_cnt = 7'd9;
    tick(1);
    err_cnt = 7'd0; lock = 1'b0; status = 1'b0;
    tick(1 + 64 + 16);
    lock = 1'b1;
    tick(1);
    checks++;
    if (link_state !== 3'd2 || retry_count !== 8'd2 || err_accum !== 16'd9) begin
      errors++;
      $display("FAIL midop_setup: st=%0d retry=%0d err=%0d, want st=2 retry=2 err=9",
               link_state, retry_count, err_accum);
    end
    rx_rst = 1'b1;
    tick(1);
    checks++;
    if ({serdes_rst_out, link_up, link_state, retry_count, err_accum, prbs_active} !==
        {1'b1, 1'b0, 3'd0, 8'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset: rst=%b up=%b st=%0d retry=%0d err=%0d, want 1 0 0 0 0",
               serdes_rst_out, link_up, link_state, retry_count, err_accum);
    end
  endtask

  task automatic test_retry_saturate();
    lock = 1'b0; status = 1'b0;
    tick(1);
    rx_rst = 1'b0;
    tick(47);
    checks++;
    if (link_state !== 3'd1 || retry_count !== 8'd0) begin
      errors++;
      $display("FAIL retry_pre_timeout: st=%0d retry=%0d, want st=1 retry=0",
               link_state, retry_count);
    end
    tick(1);
    for (int m = 2; m <= 260; m++) begin
      tick(48);
      if (m == 3) begin
        checks++;
        if (retry_count !== 8'd3 || serdes_rst_out !== 1'b1) begin
          errors++;
          $display("FAIL retry_three: retry=%0d rst=%b, want 3 1", retry_count, serdes_rst_out);
        end
      end
    end
    checks++;
    if (retry_count !== 8'd255) begin
      errors++;
      $display("FAIL retry_saturate: got %0d, want 255", retry_count);
    end
    // Clear coinciding with a timeout edge must win.
    tick(47);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    checks++;
    if (retry_count !== 8'd0 || link_state !== 3'd0) begin
      errors++;
      $display("FAIL retry_clear_wins: retry=%0d st=%0d, want 0 0", retry_count, link_state);
    end
    tick(48);
    checks++;
    if (retry_count !== 8'd1) begin
      errors++;
      $display("FAIL retry_after_clear: got %0d, want 1", retry_count);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_holdoff();
    test_err_accum();
    test_prbs();
    test_reset_midop();
    test_retry_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
